// File: rtl/capture_ctrl.sv
// capture_ctrl - capture sequencer for the logIP sampler path.
//
// Programs the sampler clock divider, records strobed sample words into an
// external ring buffer while armed, counts post-trigger samples once the
// trigger fires, then streams the captured window to the transmitter,
// newest word first.
//
// Optional feature macro: LOGIP_CTRL_ABORT_EN
//   When defined, adds input abort_i. A pulse outside IDLE returns the
//   sequencer to IDLE on the next edge, drops tx_valid_o and suppresses
//   done_o. When undefined, the port is absent and only rst_in aborts.
//
// Ports:
//   clk_i, rst_in           clock and asynchronous active-low reset
//   cfg_div_i/_stb_i        divider value and its load strobe (IDLE only)
//   cfg_read_cnt_i          returned samples = min(4*(value+1), 2^ADDR_W)
//   cfg_delay_cnt_i         post-trigger samples = 4*(value+1)
//   arm_i, run_i            start capture / trigger fired
//   smpl_stb_i, smpls_i     sampler strobe and sample word
//   fdiv_o, set_div_o       divider value and load pulse to the sampler
//   mem_we_o/_waddr_o/_wdata_o  registered RAM write port
//   mem_raddr_o, mem_rdata_i    RAM read port, data one cycle after address
//   tx_data_o/_valid_o, tx_ready_i  valid/ready stream to the transmitter
//   busy_o                  high whenever not IDLE
//   done_o                  one-cycle pulse after the last accepted word

module capture_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [23:0]       cfg_div_i,
  input  logic              cfg_div_stb_i,
  input  logic [15:0]       cfg_read_cnt_i,
  input  logic [15:0]       cfg_delay_cnt_i,
  input  logic              arm_i,
  input  logic              run_i,
  input  logic              smpl_stb_i,
  input  logic [31:0]       smpls_i,
`ifdef LOGIP_CTRL_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [23:0]       fdiv_o,
  output logic              set_div_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] DEPTH_N  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [18:0]     DEPTH_19 = 19'(DEPTH_N);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    READOUT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wptr_q;
  logic [15:0]       delay_cfg_q;
  logic [17:0]       delay_q;
  logic [ADDR_W:0]   read_total_q;
  logic [ADDR_W:0]   rd_left_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_primed_q;
  logic              first_q;

  logic [18:0]       read_words;
  logic [ADDR_W:0]   read_clamped;
  logic              wr_en;
  logic              trig;
  logic              post_done;
  logic              load;
  logic              last_hs;
  logic              abort;

`ifdef LOGIP_CTRL_ABORT_EN
  assign abort = abort_i && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  // 4*(read+1) needs 19 bits before it is clamped to the buffer depth.
  assign read_words   = {1'b0, cfg_read_cnt_i, 2'b00} + 19'd4;
  assign read_clamped = (read_words >= DEPTH_19) ? DEPTH_N : read_words[ADDR_W:0];

  assign wr_en     = ((state_q == ARMED) || (state_q == POST)) && smpl_stb_i;
  assign trig      = (state_q == ARMED) && run_i;
  // delay_q holds "samples still to come minus one", so the strobe that
  // sees zero is the final post-trigger sample.
  assign post_done = (state_q == POST) && smpl_stb_i && (delay_q == '0);
  assign load      = (state_q == READOUT) && rd_primed_q && (rd_left_q != '0) &&
                     (!tx_valid_o || tx_ready_i);
  assign last_hs   = (state_q == READOUT) && tx_valid_o && tx_ready_i && (rd_left_q == '0);

  // The read address steps down in the same cycle a word is taken, so the
  // RAM already presents the next word on the following cycle.
  assign mem_raddr_o = load ? (rd_ptr_q - ADDR_W'(1)) : rd_ptr_q;

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_i)     state_d = ARMED;
      ARMED:   if (run_i)     state_d = POST;
      POST:    if (post_done) state_d = READOUT;
      READOUT: if (last_hs)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      fdiv_o    <= '0;
      set_div_o <= 1'b0;
    end else begin
      set_div_o <= 1'b0;
      if ((state_q == IDLE) && cfg_div_stb_i) begin
        fdiv_o    <= cfg_div_i;
        set_div_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      wptr_q      <= '0;
    end else begin
      mem_we_o <= wr_en;
      if ((state_q == IDLE) && arm_i) begin
        wptr_q <= '0;
      end
      if (wr_en) begin
        mem_waddr_o <= wptr_q;
        mem_wdata_o <= smpls_i;
        wptr_q      <= wptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      read_total_q <= '0;
      delay_cfg_q  <= '0;
      delay_q      <= '0;
    end else begin
      if ((state_q == IDLE) && arm_i) begin
        read_total_q <= read_clamped;
        delay_cfg_q  <= cfg_delay_cnt_i;
      end
      // A strobe coinciding with the trigger is already delay sample 1.
      if (trig) begin
        delay_q <= smpl_stb_i ? {delay_cfg_q, 2'b10} : {delay_cfg_q, 2'b11};
      end else if ((state_q == POST) && smpl_stb_i && (delay_q != '0)) begin
        delay_q <= delay_q - 18'd1;
      end
    end
  end

  // The newest word is still in flight to the RAM during the first READOUT
  // cycle, so it is taken from the write data register instead of the RAM.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      rd_primed_q <= 1'b0;
      first_q     <= 1'b0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= last_hs && !abort;
      if (post_done) begin
        rd_ptr_q    <= wptr_q;
        rd_left_q   <= read_total_q;
        rd_primed_q <= 1'b0;
        first_q     <= 1'b1;
      end else if (state_q == READOUT) begin
        rd_primed_q <= 1'b1;
        if (load) begin
          rd_ptr_q  <= rd_ptr_q - ADDR_W'(1);
          rd_left_q <= rd_left_q - (ADDR_W+1)'(1);
          first_q   <= 1'b0;
          tx_data_o <= first_q ? mem_wdata_o : mem_rdata_i;
        end
      end

      if (abort) begin
        tx_valid_o <= 1'b0;
      end else if (load) begin
        tx_valid_o <= 1'b1;
      end else if (tx_valid_o && tx_ready_i) begin
        tx_valid_o <= 1'b0;
      end
    end
  end

endmodule
